// File: rtl/zero_run_detect_pkg.sv
// Shared definitions for the zero-run detector.
// State codes and default parameters.
package zero_run_detect_pkg;

  localparam int DEF_WIDTH   = 3;
  localparam int DEF_RUN_LEN = 4;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HIT  = 2'b10
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with clear and optional saturation.
// clr and inc together load the value 1.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         sat_en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] base;
  logic         full;

  // Start from zero when clearing, else from the held value.
  always_comb begin
    base = clr ? '0 : cnt;
    full = sat_en && (base == '1);
  end

  // Count, holding at all-ones when saturation is enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || inc) begin
      cnt <= (inc && !full) ? base + W'(1) : base;
    end
  end

endmodule

// File: rtl/zero_run_detect.sv
// Detects runs of RUN_LEN valid all-zero samples.
// Overlapping or segmented detection, counters out.
module zero_run_detect
  import zero_run_detect_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int RUN_LEN = DEF_RUN_LEN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inp,
  input  logic             inp_valid,
  input  logic             overlap,
  output logic             det,
  output logic [1:0]       outp,
  output logic [CNT_W-1:0] run_cnt,
  output logic [CNT_W-1:0] hit_cnt
);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] seg;
  logic             vz;
  logic             vnz;
  logic             seg_clr;
  logic             seg_inc;
  logic             to_hit;

  // Qualify the sample as a valid zero or valid non-zero.
  always_comb begin
    vz  = inp_valid && (inp == '0);
    vnz = inp_valid && (inp != '0);
  end

  // Next state and segment-counter control.
  always_comb begin
    nxt     = state;
    seg_clr = 1'b0;
    seg_inc = 1'b0;
    to_hit  = 1'b0;
    if (vnz) begin
      seg_clr = 1'b1;
      nxt     = ST_IDLE;
    end else if (vz) begin
      unique case (state)
        ST_HIT: begin
          if (overlap) begin
            seg_inc = 1'b1;
            to_hit  = 1'b1;
            nxt     = ST_HIT;
          end else begin
            seg_clr = 1'b1;
            seg_inc = 1'b1;
            nxt     = ST_RUN;
          end
        end
        default: begin
          seg_inc = 1'b1;
          if (seg == CNT_W'(RUN_LEN - 1)) begin
            to_hit = 1'b1;
            nxt    = ST_HIT;
          end else begin
            nxt = ST_RUN;
          end
        end
      endcase
    end
  end

  // State register and registered detect pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      det   <= 1'b0;
    end else begin
      state <= nxt;
      det   <= to_hit;
    end
  end

  assign outp = state;

  sat_counter #(.W(CNT_W)) u_run (
    .clk    (clk),
    .rst    (rst),
    .clr    (vnz),
    .inc    (vz),
    .sat_en (1'b1),
    .cnt    (run_cnt)
  );

  sat_counter #(.W(CNT_W)) u_seg (
    .clk    (clk),
    .rst    (rst),
    .clr    (seg_clr),
    .inc    (seg_inc),
    .sat_en (1'b1),
    .cnt    (seg)
  );

  sat_counter #(.W(CNT_W)) u_hit (
    .clk    (clk),
    .rst    (rst),
    .clr    (1'b0),
    .inc    (to_hit),
    .sat_en (1'b0),
    .cnt    (hit_cnt)
  );

endmodule

// File: tb/tb_zero_run_detect.sv
// Randomized and directed bench for zero_run_detect.
// Outputs compared to a behavioural run model.
module tb_zero_run_detect;

  localparam int W  = 3;
  localparam int RL = 4;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic [W-1:0]  inp;
  logic          inp_valid;
  logic          overlap;
  logic          det;
  logic [1:0]    outp;
  logic [CW-1:0] run_cnt;
  logic [CW-1:0] hit_cnt;

  int checks;
  int errors;

  int m_run;
  int m_seg;
  int m_hits;
  bit m_hit;
  bit m_det;
  int m_state;

  zero_run_detect #(
    .WIDTH   (W),
    .RUN_LEN (RL),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inp       (inp),
    .inp_valid (inp_valid),
    .overlap   (overlap),
    .det       (det),
    .outp      (outp),
    .run_cnt   (run_cnt),
    .hit_cnt   (hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Reference: run length in zeros, segment length, hit while segment >= RL.
  task automatic model(input bit r, input bit v, input int x, input bit ov);
    m_det = 1'b0;
    if (r) begin
      m_run = 0; m_seg = 0; m_hits = 0;
      m_hit = 1'b0; m_state = 0;
    end else if (v) begin
      if (x != 0) begin
        m_run = 0; m_seg = 0;
        m_hit = 1'b0; m_state = 0;
      end else begin
        m_run = (m_run + 1 > 255) ? 255 : m_run + 1;
        if (m_hit && !ov) m_seg = 1;
        else m_seg = m_seg + 1;
        m_hit = (m_seg >= RL);
        if (m_hit) begin
          m_det = 1'b1;
          m_hits = (m_hits + 1) % 256;
        end
        m_state = m_hit ? 2 : 1;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit v, input int x, input bit ov);
    rst = r;
    inp_valid = v;
    inp = W'(x);
    overlap = ov;
    @(posedge clk);
    model(r, v, x, ov);
    #1;
    chk("det", int'(det), int'(m_det));
    chk("outp", int'(outp), m_state);
    chk("run_cnt", int'(run_cnt), m_run);
    chk("hit_cnt", int'(hit_cnt), m_hits);
  endtask

  task automatic zeros(input int n, input bit ov);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 0, ov);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; inp = '0; inp_valid = 1'b0; overlap = 1'b0;

    cyc(1'b1, 1'b0, 0, 1'b0);
    cyc(1'b1, 1'b0, 0, 1'b0);
    chk("rst_outp", int'(outp), 0);
    chk("rst_hit", int'(hit_cnt), 0);

    zeros(3, 1'b0);
    chk("pre_det", int'(det), 0);
    zeros(1, 1'b0);
    chk("first_det", int'(det), 1);
    chk("first_outp", int'(outp), 2);
    chk("first_run", int'(run_cnt), 4);
    chk("first_hit", int'(hit_cnt), 1);
    cyc(1'b0, 1'b1, 1, 1'b0);
    chk("det_once", int'(det), 0);

    cyc(1'b1, 1'b0, 0, 1'b1);
    zeros(7, 1'b1);
    chk("ovl_hit", int'(hit_cnt), 4);
    chk("ovl_run", int'(run_cnt), 7);

    cyc(1'b1, 1'b0, 0, 1'b0);
    zeros(9, 1'b0);
    chk("nov_hit", int'(hit_cnt), 2);
    chk("nov_outp", int'(outp), 1);

    cyc(1'b1, 1'b0, 0, 1'b0);
    zeros(3, 1'b0);
    cyc(1'b0, 1'b1, 5, 1'b0);
    chk("brk_run", int'(run_cnt), 0);
    chk("brk_outp", int'(outp), 0);
    zeros(4, 1'b0);
    chk("brk_det", int'(det), 1);

    cyc(1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 0, 1'b0);
      cyc(1'b0, 1'b0, $urandom_range(1, 7), 1'b0);
    end
    chk("gap_hit", int'(hit_cnt), 1);
    chk("gap_run", int'(run_cnt), 4);

    cyc(1'b1, 1'b0, 0, 1'b0);
    zeros(4, 1'b0);
    cyc(1'b1, 1'b1, 0, 1'b0);
    chk("rhit_outp", int'(outp), 0);
    chk("rhit_run", int'(run_cnt), 0);
    zeros(260, 1'b0);
    chk("sat_run", int'(run_cnt), 255);
    chk("sat_hit", int'(hit_cnt), 65);

    for (int i = 0; i < 1500; i++) begin
      bit r, v, ov;
      int x;
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 9) < 8);
      x = ($urandom_range(0, 9) < 8) ? 0 : $urandom_range(1, 7);
      ov = ($urandom_range(0, 39) == 0) ? ~overlap : overlap;
      cyc(r, v, x, ov);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
